// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one ripple-carry add/sub unit among NUM_REQ requesters.
// One op in flight: grant in IDLE, compute in EXEC, hold the response in RESP.
module adder_rr_scheduler #(
  parameter int BIT_WIDTH = 16,
  parameter int NUM_REQ   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]           req_op,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [BIT_WIDTH-1:0]         rsp_sum,
  output logic                         rsp_cout,
  output logic                         rsp_ovf,
  output logic [NUM_REQ-1:0]           ovf_flags,
  input  logic [NUM_REQ-1:0]           ovf_clr,
  output logic                         busy
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int MSB  = BIT_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      win_id;
  logic [ID_W:0]        scan;
  logic                 win_found;
  logic [BIT_WIDTH-1:0] sel_a;
  logic [BIT_WIDTH-1:0] sel_b;
  logic                 sel_op;

  logic [BIT_WIDTH-1:0] op_a;
  logic [BIT_WIDTH-1:0] op_b;
  logic                 op_sub;
  logic [ID_W-1:0]      op_id;

  logic [BIT_WIDTH-1:0] add_b;
  logic [BIT_WIDTH-1:0] add_sum;
  logic                 add_cout;
  logic                 add_ovf;
  logic                 carry;

  logic                 grant;
  logic                 exec_done;
  logic                 rsp_done;
  logic [NUM_REQ-1:0]   ovf_set;

  // Scan backwards so the last hit is the first requester at or after rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_id    = rr_ptr;
    scan      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan = {1'b0, rr_ptr} + (ID_W + 1)'(k);
      if (scan >= (ID_W + 1)'(NUM_REQ)) begin
        scan = scan - (ID_W + 1)'(NUM_REQ);
      end
      if (req_valid[scan[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = scan[ID_W-1:0];
      end
    end
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_id == ID_W'(i)) begin
        sel_a  = req_a[i*BIT_WIDTH +: BIT_WIDTH];
        sel_b  = req_b[i*BIT_WIDTH +: BIT_WIDTH];
        sel_op = req_op[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    grant     = 1'b0;
    exec_done = 1'b0;
    rsp_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          grant             = 1'b1;
          req_ready[win_id] = 1'b1;
          state_nxt         = EXEC;
        end
      end
      EXEC: begin
        exec_done = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy  = (state != IDLE);
  assign add_b = op_sub ? ~op_b : op_b;

  // Shared adder: subtraction is a + ~b + 1, fed only from the operand registers.
  always_comb begin
    add_sum = '0;
    carry   = op_sub;
    for (int i = 0; i < BIT_WIDTH; i++) begin
      add_sum[i] = op_a[i] ^ add_b[i] ^ carry;
      carry      = (op_a[i] & add_b[i]) | (carry & (op_a[i] ^ add_b[i]));
    end
    add_cout = carry;
  end

  always_comb begin
    if (op_sub) begin
      add_ovf = (op_a[MSB] != op_b[MSB]) && (add_sum[MSB] != op_a[MSB]);
    end else begin
      add_ovf = (op_a[MSB] == op_b[MSB]) && (add_sum[MSB] != op_a[MSB]);
    end
  end

  always_comb begin
    ovf_set = '0;
    if (exec_done && add_ovf) begin
      ovf_set[op_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_sub    <= 1'b0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_ovf   <= 1'b0;
      ovf_flags <= '0;
    end else begin
      if (grant) begin
        op_a   <= sel_a;
        op_b   <= sel_b;
        op_sub <= sel_op;
        op_id  <= win_id;
      end
      if (exec_done) begin
        rsp_valid <= 1'b1;
        rsp_id    <= op_id;
        rsp_sum   <= add_sum;
        rsp_cout  <= add_cout;
        rsp_ovf   <= add_ovf;
      end
      if (rsp_done) begin
        rsp_valid <= 1'b0;
        if (rsp_id == ID_W'(NUM_REQ - 1)) begin
          rr_ptr <= '0;
        end else begin
          rr_ptr <= rsp_id + ID_W'(1);
        end
      end
      // Set wins over a coincident clear.
      ovf_flags <= (ovf_flags & ~ovf_clr) | ovf_set;
    end
  end

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Bench for adder_rr_scheduler: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_adder_rr_scheduler;

  localparam int W = 16;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_op;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic           rsp_ovf;
  logic [N-1:0]   ovf_flags;
  logic [N-1:0]   ovf_clr;
  logic           busy;

  always #5 clk = ~clk;

  adder_rr_scheduler #(.BIT_WIDTH(W), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
    .ovf_flags(ovf_flags), .ovf_clr(ovf_clr),
    .busy(busy)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Requester side stimulus
  bit           pend[N];
  logic [W-1:0] pa[N];
  logic [W-1:0] pb[N];
  bit           pop[N];
  bit           refill;

  // Model: age 0 = no op, 1 = op just accepted, 2 = result posted
  bit           m_live;
  int           m_age;
  int           m_ptr;
  int           m_cid;
  int           m_id;
  int           m_acc;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  bit           m_op;
  logic [W-1:0] m_sum;
  bit           m_cout;
  bit           m_ovf;
  bit           m_rv;
  logic [N-1:0] m_flags;

  always @(negedge clk) begin : model
    int win;
    int j;
    int ua;
    int ub;
    int sa;
    int sb;
    int r;
    logic [N-1:0] er;
    logic [N-1:0] nf;
    win = -1;
    if (m_live && m_age == 0) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (win < 0 && req_valid[j]) win = j;
      end
    end
    er = '0;
    if (win >= 0) er[win] = 1'b1;
    if (m_live) begin
      chk("m_req_ready", req_ready, er);
      chk("m_busy", busy, m_age != 0);
      chk("m_rsp_valid", rsp_valid, m_rv);
      chk("m_rsp_id", rsp_id, m_id);
      chk("m_rsp_sum", rsp_sum, m_sum);
      chk("m_rsp_cout", rsp_cout, m_cout);
      chk("m_rsp_ovf", rsp_ovf, m_ovf);
      chk("m_ovf_flags", ovf_flags, m_flags);
    end
    m_acc = -1;
    if (rst) begin
      m_live = 1; m_age = 0; m_ptr = 0; m_id = 0; m_cid = 0;
      m_sum = '0; m_cout = 0; m_ovf = 0; m_rv = 0; m_flags = '0;
    end else if (m_live) begin
      nf = m_flags & ~ovf_clr;
      if (m_age == 0) begin
        if (win >= 0) begin
          m_a = req_a[win*W +: W];
          m_b = req_b[win*W +: W];
          m_op = req_op[win];
          m_cid = win;
          m_acc = win;
          m_age = 1;
        end
      end else if (m_age == 1) begin
        ua = int'(m_a);
        ub = int'(m_b);
        sa = int'($signed(m_a));
        sb = int'($signed(m_b));
        if (m_op) begin
          m_sum = W'(ua - ub);
          m_cout = (ua >= ub);
          r = sa - sb;
        end else begin
          m_sum = W'(ua + ub);
          m_cout = (ua + ub) >= 65536;
          r = sa + sb;
        end
        m_ovf = (r > 32767) || (r < -32768);
        m_id = m_cid;
        m_rv = 1;
        m_age = 2;
        if (m_ovf) nf[m_id] = 1'b1;
      end else if (rsp_ready) begin
        m_rv = 0;
        m_ptr = (m_id + 1) % N;
        m_age = 0;
      end
      m_flags = nf;
    end
  end

  function automatic logic [W-1:0] rop();
    case ($urandom_range(0, 4))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'h0001;
      default: return W'($urandom());
    endcase
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_a[i*W +: W] = pa[i];
      req_b[i*W +: W] = pb[i];
      req_op[i] = pop[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (m_acc >= 0) begin
      if (refill) begin
        pa[m_acc] = rop();
        pb[m_acc] = rop();
      end else begin
        pend[m_acc] = 0;
      end
    end
  endtask

  task automatic step();
    tick();
    drive();
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit op);
    pend[i] = 1; pa[i] = a; pb[i] = b; pop[i] = op;
  endtask

  task automatic do_reset();
    rst = 1; rsp_ready = 1; ovf_clr = '0; refill = 0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    drive();
    @(posedge clk);
    #1;
    rst = 0;
    drive();
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < N; i++) pend[i] = 0;
    rsp_ready = 1;
    drive();
    repeat (4) step();
  endtask

  task automatic rnd_stim();
    for (int i = 0; i < N; i++) begin
      if (pend[i]) begin
        if ($urandom_range(0, 19) == 0) pend[i] = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        set_req(i, rop(), rop(), 1'($urandom_range(0, 1)));
      end else begin
        pa[i] = W'($urandom());
        pb[i] = W'($urandom());
      end
    end
    rsp_ready = ($urandom_range(0, 3) != 0);
    ovf_clr = ($urandom_range(0, 7) == 0) ? N'($urandom()) : '0;
    rst = ($urandom_range(0, 299) == 0);
  endtask

  int g_id[8];
  int g_cyc[8];
  int ng;
  int exp_ord[5] = '{0, 1, 2, 3, 0};
  logic [W-1:0] held;

  initial begin
    m_live = 0; m_age = 0; m_acc = -1; refill = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; pa[i] = '0; pb[i] = '0; pop[i] = 0;
    end
    ovf_clr = '0; rsp_ready = 1; rst = 1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_sum", rsp_sum, 0);
    chk("reset_flags", ovf_flags, 0);
    chk("reset_ready", req_ready, 0);

    // Single add, two-cycle latency
    set_req(0, 16'h0003, 16'h0004, 0);
    drive(); #1;
    chk("t1_ready", req_ready, 4'b0001);
    step();
    chk("t1_ready_once", req_ready, 0);
    chk("t1_exec_valid", rsp_valid, 0);
    step();
    chk("t1_valid", rsp_valid, 1);
    chk("t1_id", rsp_id, 0);
    chk("t1_sum", rsp_sum, 16'h0007);
    chk("t1_cout", rsp_cout, 0);
    chk("t1_ovf", rsp_ovf, 0);

    // Fairness with all four continuously requesting
    do_reset();
    refill = 1;
    for (int i = 0; i < N; i++) set_req(i, rop(), rop(), 0);
    drive(); #1;
    ng = 0;
    for (int c = 0; c < 14; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req_ready[i] && ng < 8) begin
          g_id[ng] = i; g_cyc[ng] = c; ng++;
        end
      end
      step();
    end
    chk("t2_grants", ng, 5);
    for (int k = 0; k < 5; k++) chk("t2_order", g_id[k], exp_ord[k]);
    for (int k = 1; k < 5; k++) chk("t2_gap", g_cyc[k] - g_cyc[k-1], 3);
    refill = 0;

    // Signed overflow on add and sub
    do_reset();
    set_req(1, 16'h7FFF, 16'h0001, 0);
    drive();
    step(); step();
    chk("t3a_sum", rsp_sum, 16'h8000);
    chk("t3a_ovf", rsp_ovf, 1);
    chk("t3a_flags", ovf_flags, 4'b0010);
    step();
    set_req(2, 16'h8000, 16'h0001, 1);
    drive();
    step(); step();
    chk("t3b_id", rsp_id, 2);
    chk("t3b_sum", rsp_sum, 16'h7FFF);
    chk("t3b_cout", rsp_cout, 1);
    chk("t3b_ovf", rsp_ovf, 1);
    chk("t3b_flags", ovf_flags, 4'b0110);

    // Backpressure held for five cycles in RESP
    step();
    set_req(3, 16'h1111, 16'h2222, 0);
    rsp_ready = 0;
    drive();
    step();
    set_req(0, 16'h0005, 16'h0006, 0);
    drive();
    step();
    for (int c = 0; c < 5; c++) begin
      chk("t4_valid", rsp_valid, 1);
      chk("t4_sum", rsp_sum, 16'h3333);
      chk("t4_ready", req_ready, 0);
      chk("t4_busy", busy, 1);
      if (c < 4) step();
    end
    rsp_ready = 1;
    drive();
    step();
    chk("t4_idle", busy, 0);
    chk("t4_rv_low", rsp_valid, 0);
    chk("t4_next_grant", req_ready, 4'b0001);
    drain();

    // Operands changed after acceptance must not leak in
    set_req(0, 16'h1234, 16'h0001, 0);
    drive();
    tick();
    pa[0] = 16'hFFFF; pb[0] = 16'hFFFF; pop[0] = 1;
    drive(); #1;
    step();
    chk("t5_sum", rsp_sum, 16'h1235);
    drain();

    // Clear coincident with set keeps the bit; clear alone drops it
    set_req(1, 16'h7FFF, 16'h0001, 0);
    drive();
    tick();
    ovf_clr = 4'b0010;
    drive(); #1;
    tick();
    ovf_clr = '0;
    drive(); #1;
    chk("t6_set_wins", ovf_flags, 4'b0110);
    drain();
    ovf_clr = 4'b0010;
    drive();
    step();
    ovf_clr = '0;
    drive();
    step();
    chk("t6_clear", ovf_flags, 4'b0100);

    // Reset while an op is executing
    set_req(0, 16'h0001, 16'h0001, 0);
    drive();
    tick();
    rst = 1;
    drive(); #1;
    tick();
    rst = 0;
    drive(); #1;
    chk("t6r_valid", rsp_valid, 0);
    chk("t6r_busy", busy, 0);
    chk("t6r_flags", ovf_flags, 0);
    chk("t6r_sum", rsp_sum, 0);
    chk("t6r_ready", req_ready, 0);
    step();
    chk("t6r_no_rsp", rsp_valid, 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      rnd_stim();
      drive();
    end
    tick();
    rst = 0;
    drive();
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
